// File: rtl/secure_regfile_pkg.sv
// rtl/secure_regfile_pkg.sv - shared lock-state type and default key/window constants
package secure_regfile_pkg;

   typedef enum logic [1:0] {
      LOCKED   = 2'd0,
      UNLOCKED = 2'd1,
      LOCKOUT  = 2'd2
   } lock_state_t;

   localparam logic [15:0] DEF_KEY_VAL       = 16'h0032;
   localparam int          DEF_UNLOCK_CYCLES = 64;
   localparam int          DEF_MAX_FAIL      = 3;

endpackage

// File: rtl/key_lock_fsm.sv
// rtl/key_lock_fsm.sv - key-gated lock FSM with unlock window and bad-key lockout
module key_lock_fsm
   import secure_regfile_pkg::*;
#(
   parameter int               KEY_W         = 16,
   parameter logic [KEY_W-1:0] KEY_VAL       = KEY_W'(DEF_KEY_VAL),
   parameter int               UNLOCK_CYCLES = DEF_UNLOCK_CYCLES,
   parameter int               MAX_FAIL      = DEF_MAX_FAIL
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_valid,
   input  logic [KEY_W-1:0] key_in,
   input  logic             relock,
   output logic             unlocked,
   output logic             lockout
);

   localparam int CW = $clog2(UNLOCK_CYCLES + 1);
   localparam int FW = $clog2(MAX_FAIL + 1);

   lock_state_t   state;
   logic [CW-1:0] win_cnt;
   logic [FW-1:0] fail_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= LOCKED;
         win_cnt  <= '0;
         fail_cnt <= '0;
      end else begin
         case (state)
            LOCKED: begin
               if (key_valid) begin
                  if (key_in == KEY_VAL) begin
                     state    <= UNLOCKED;
                     fail_cnt <= '0;
                     win_cnt  <= CW'(UNLOCK_CYCLES - 1);
                  end else begin
                     fail_cnt <= fail_cnt + FW'(1);
                     if (fail_cnt + FW'(1) >= FW'(MAX_FAIL))
                        state <= LOCKOUT;
                  end
               end
            end
            UNLOCKED: begin
               // the cycle that sees zero is the last authorised one
               if (relock || win_cnt == '0)
                  state <= LOCKED;
               else
                  win_cnt <= win_cnt - CW'(1);
            end
            LOCKOUT: state <= LOCKOUT;
            default: state <= LOCKED;
         endcase
      end
   end

   assign unlocked = (state == UNLOCKED);
   assign lockout  = (state == LOCKOUT);

endmodule

// File: rtl/secure_regfile.sv
// rtl/secure_regfile.sv - register file with write-first bypass and key-protected registers
module secure_regfile
   import secure_regfile_pkg::*;
#(
   parameter int               XLEN          = 32,
   parameter int               NREGS         = 32,
   parameter logic [NREGS-1:0] PROT_MASK     = NREGS'(32'hFFFF_0000),
   parameter int               KEY_W         = 16,
   parameter logic [KEY_W-1:0] KEY_VAL       = KEY_W'(DEF_KEY_VAL),
   parameter int               UNLOCK_CYCLES = DEF_UNLOCK_CYCLES,
   parameter int               MAX_FAIL      = DEF_MAX_FAIL,
   localparam int              AW            = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rd_en,
   input  logic [AW-1:0]    rs1_addr,
   input  logic [AW-1:0]    rs2_addr,
   output logic [XLEN-1:0]  rs1_data,
   output logic [XLEN-1:0]  rs2_data,
   input  logic             ld_we,
   input  logic [AW-1:0]    ld_addr,
   input  logic [XLEN-1:0]  ld_data,
   input  logic             alu_we,
   input  logic [AW-1:0]    alu_addr,
   input  logic [XLEN-1:0]  alu_data,
   input  logic             st_re,
   input  logic [AW-1:0]    st_addr,
   output logic [XLEN-1:0]  st_data,
   output logic             st_valid,
   input  logic             key_valid,
   input  logic [KEY_W-1:0] key_in,
   input  logic             relock,
   output logic             unlocked,
   output logic             lockout,
   output logic             violation
);

   logic [XLEN-1:0] regs [NREGS];
   logic            ld_blk, alu_blk, ld_ok, alu_ok, viol_d;

   key_lock_fsm #(
      .KEY_W         (KEY_W),
      .KEY_VAL       (KEY_VAL),
      .UNLOCK_CYCLES (UNLOCK_CYCLES),
      .MAX_FAIL      (MAX_FAIL)
   ) u_lock (
      .clk       (clk),
      .rst       (rst),
      .key_valid (key_valid),
      .key_in    (key_in),
      .relock    (relock),
      .unlocked  (unlocked),
      .lockout   (lockout)
   );

   // gating uses the lock state held at this edge, so a same-cycle key never authorises
   function automatic logic guarded(input logic [AW-1:0] a);
      return (a != '0) && PROT_MASK[a] && !unlocked;
   endfunction

   function automatic logic [XLEN-1:0] fwd(input logic [AW-1:0] a);
      if (a == '0 || guarded(a)) return '0;
      if (alu_ok && alu_addr == a) return alu_data;
      if (ld_ok && ld_addr == a) return ld_data;
      return regs[a];
   endfunction

   assign ld_blk  = ld_we && guarded(ld_addr);
   assign alu_blk = alu_we && guarded(alu_addr);
   assign ld_ok   = ld_we && (ld_addr != '0) && !ld_blk;
   assign alu_ok  = alu_we && (alu_addr != '0) && !alu_blk;
   assign viol_d  = ld_blk || alu_blk
                 || (rd_en && (guarded(rs1_addr) || guarded(rs2_addr)))
                 || (st_re && guarded(st_addr))
                 || (key_valid && lockout);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         rs1_data  <= '0;
         rs2_data  <= '0;
         st_data   <= '0;
         st_valid  <= 1'b0;
         violation <= 1'b0;
      end else begin
         if (ld_ok)  regs[ld_addr]  <= ld_data;
         if (alu_ok) regs[alu_addr] <= alu_data;
         if (rd_en) begin
            rs1_data <= fwd(rs1_addr);
            rs2_data <= fwd(rs2_addr);
         end
         if (st_re) st_data <= fwd(st_addr);
         st_valid  <= st_re;
         violation <= viol_d;
      end
   end

endmodule
